// File: rtl/counter_sequencer_pkg.sv
// counter_seq_pkg: opcodes, FSM states and status-bit positions shared by the counter sequencer
package counter_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_LOAD,
        OP_SET_CMP,
        OP_SET_PRESC,
        OP_RUN_UP,
        OP_RUN_DOWN,
        OP_ONESHOT,
        OP_STOP
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_SHOT
    } state_e;

    localparam int STROBE_BIT = 3;
    localparam int BUSY_BIT   = 4;
    localparam int MATCH_BIT  = 5;
    localparam int DONE_BIT   = 6;
    localparam int WRAP_BIT   = 7;

    localparam logic [7:0] OE_MASK = 8'hF0;

endpackage

// File: rtl/counter_sequencer_cmd_sync.sv
// cmd_sync: brings the asynchronous command strobe into clk and turns each rising edge into a one-cycle pulse
module cmd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // shift the pin through the synchronizer; prev holds the last synchronized level for edge detection
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], strobe};
        prev_d = sync_q[STAGES-1];
    end

    // synchronizer and edge flops, all cleared while in reset so a held strobe re-arms after release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: strobe-driven 8-bit up/down/one-shot counter with prescaler, compare and sticky status
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter logic [7:0] CMP_RESET   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       pulse, cmd, tick;
    opcode_e    op;
    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] cmp_q, cmp_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic       done_q, done_d;
    logic       wrap_q, wrap_d;
    logic       unused_ok;

    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    cmd_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (uio_in[STROBE_BIT]),
        .pulse  (pulse)
    );

    assign op   = opcode_e'(uio_in[2:0]);
    assign cmd  = pulse && (op != OP_NOP);
    assign tick = (state_q != ST_IDLE) && !cmd && (pcnt_q == presc_q);

    // next state: a command takes priority and swallows any coincident tick, otherwise the prescaler runs
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        done_d  = done_q;
        wrap_d  = wrap_q;
        if (cmd) begin
            pcnt_d = 8'd0;
            done_d = 1'b0;
            case (op)
                OP_LOAD: begin
                    count_d = ui_in;
                    wrap_d  = 1'b0;
                end
                OP_SET_CMP:   cmp_d   = ui_in;
                OP_SET_PRESC: presc_d = ui_in;
                OP_RUN_UP:    state_d = ST_UP;
                OP_RUN_DOWN:  state_d = ST_DOWN;
                OP_ONESHOT:   state_d = ST_SHOT;
                OP_STOP:      state_d = ST_IDLE;
                default: ;
            endcase
        end else if (state_q == ST_IDLE) begin
            pcnt_d = 8'd0;
        end else if (!tick) begin
            pcnt_d = pcnt_q + 8'd1;
        end else begin
            pcnt_d = 8'd0;
            case (state_q)
                ST_UP: begin
                    count_d = count_q + 8'd1;
                    wrap_d  = wrap_q | (count_q == 8'hFF);
                end
                ST_DOWN: begin
                    count_d = count_q - 8'd1;
                    wrap_d  = wrap_q | (count_q == 8'h00);
                end
                ST_SHOT: begin
                    if (count_q == cmp_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + 8'd1;
                        wrap_d  = wrap_q | (count_q == 8'hFF);
                    end
                end
                default: ;
            endcase
        end
    end

    // all sequencer state, reset synchronously so a mid-run reset aborts on the next edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
            cmp_q   <= CMP_RESET;
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // status byte: match is live from the registers, the other bits are registered state
    always_comb begin
        uio_out            = 8'h00;
        uio_out[BUSY_BIT]  = state_q != ST_IDLE;
        uio_out[MATCH_BIT] = count_q == cmp_q;
        uio_out[DONE_BIT]  = done_q;
        uio_out[WRAP_BIT]  = wrap_q;
    end

    assign uo_out = count_q;
    assign uio_oe = OE_MASK;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed scenarios plus randomized commands checked against a behavioural model
`timescale 1ns/1ps
module tb_counter_sequencer;

    localparam int         SS      = 2;
    localparam logic [7:0] CMP_RST = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int errors = 0;
    int checks = 0;

    // behavioural model: mode 0 idle, 1 up, 2 down, 3 one-shot; hist[0] is the strobe seen at the previous edge
    logic [7:0] m_count = 8'h00, m_cmp = CMP_RST, m_presc = 8'h00;
    int         m_pcnt = 0, m_mode = 0;
    logic       m_done = 1'b0, m_wrap = 1'b0;
    logic [SS:0] hist = '0;

    counter_sequencer #(.CMP_RESET(CMP_RST), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // a command lands SS edges after its strobe is first seen high, provided it was seen low just before
    task automatic model_step();
        int nv;
        if (!rst_n) begin
            m_count = 8'h00; m_cmp = CMP_RST; m_presc = 8'h00; m_pcnt = 0;
            m_mode = 0; m_done = 1'b0; m_wrap = 1'b0; hist = '0;
        end else begin
            if (hist[SS-1] && !hist[SS] && uio_in[2:0] != 3'd0) begin
                m_pcnt = 0;
                m_done = 1'b0;
                case (uio_in[2:0])
                    3'd1: begin m_count = ui_in; m_wrap = 1'b0; end
                    3'd2: m_cmp = ui_in;
                    3'd3: m_presc = ui_in;
                    3'd4: m_mode = 1;
                    3'd5: m_mode = 2;
                    3'd6: m_mode = 3;
                    default: m_mode = 0;
                endcase
            end else if (m_mode != 0) begin
                if (m_pcnt == int'(m_presc)) begin
                    m_pcnt = 0;
                    if (m_mode == 3 && m_count == m_cmp) begin
                        m_mode = 0;
                        m_done = 1'b1;
                    end else begin
                        nv = int'(m_count) + (m_mode == 2 ? -1 : 1);
                        if (nv < 0 || nv > 255) m_wrap = 1'b1;
                        m_count = 8'(nv & 255);
                    end
                end else begin
                    m_pcnt++;
                end
            end
            hist = {hist[SS-1:0], uio_in[3]};
        end
    endtask

    function automatic logic [7:0] exp_uio();
        return {m_wrap, m_done, m_count == m_cmp, m_mode != 0, 4'b0000};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // one low edge to re-arm the edge detector, then hold the strobe until the command takes effect
    task automatic send(input logic [2:0] op, input logic [7:0] arg);
        uio_in[3] = 1'b0;
        cyc();
        ui_in  = arg;
        uio_in = {4'b0000, 1'b1, op};
        repeat (SS + 1) cyc();
        uio_in[3] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 00", uo_out); end checks++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", uio_out); end checks++;
        if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_oe: got %h want f0", uio_oe); end checks++;
        rst_n = 1'b1;
        cyc();
        if (uio_out !== 8'h00) begin errors++; $display("FAIL idle_after_reset: got %h want 00", uio_out); end checks++;
    endtask

    task automatic test_run_up();
        logic [7:0] e;
        send(3'd1, 8'h10);
        send(3'd4, 8'h00);
        if (uo_out !== 8'h10 || uio_out[4] !== 1'b1) begin errors++; $display("FAIL run_up_start: got %h busy %b want 10 busy 1", uo_out, uio_out[4]); end checks++;
        repeat (5) cyc();
        if (uo_out !== 8'h15) begin errors++; $display("FAIL run_up_five: got %h want 15", uo_out); end checks++;
        send(3'd7, 8'h00);
        e = 8'h15 + 8'(SS + 1);
        if (uo_out !== e || uio_out[4] !== 1'b0) begin errors++; $display("FAIL stop: got %h busy %b want %h busy 0", uo_out, uio_out[4], e); end checks++;
        repeat (5) cyc();
        if (uo_out !== e) begin errors++; $display("FAIL stop_held: got %h want %h", uo_out, e); end checks++;
    endtask

    task automatic test_prescale();
        logic [7:0] e;
        send(3'd3, 8'd3);
        send(3'd1, 8'h00);
        send(3'd4, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            e = 8'(i / 4);
            if (uo_out !== e) begin errors++; $display("FAIL prescale_edge%0d: got %h want %h", i, uo_out, e); end checks++;
        end
        send(3'd7, 8'h00);
    endtask

    task automatic test_wrap();
        send(3'd3, 8'd0);
        send(3'd1, 8'hFE);
        send(3'd4, 8'h00);
        cyc();
        if (uo_out !== 8'hFF || uio_out[7] !== 1'b0) begin errors++; $display("FAIL wrap_up_ff: got %h wrap %b want ff wrap 0", uo_out, uio_out[7]); end checks++;
        cyc();
        if (uo_out !== 8'h00 || uio_out[7] !== 1'b1) begin errors++; $display("FAIL wrap_up_00: got %h wrap %b want 00 wrap 1", uo_out, uio_out[7]); end checks++;
        send(3'd7, 8'h00);
        if (uio_out[7] !== 1'b1) begin errors++; $display("FAIL wrap_sticky: got %b want 1", uio_out[7]); end checks++;
        send(3'd1, 8'h00);
        if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL wrap_load_clear: got %b want 0", uio_out[7]); end checks++;
        send(3'd1, 8'h01);
        send(3'd5, 8'h00);
        cyc();
        if (uo_out !== 8'h00 || uio_out[7] !== 1'b0) begin errors++; $display("FAIL wrap_down_00: got %h wrap %b want 00 wrap 0", uo_out, uio_out[7]); end checks++;
        cyc();
        if (uo_out !== 8'hFF || uio_out[7] !== 1'b1) begin errors++; $display("FAIL wrap_down_ff: got %h wrap %b want ff wrap 1", uo_out, uio_out[7]); end checks++;
        send(3'd7, 8'h00);
        send(3'd1, 8'h00);
        if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL wrap_down_clear: got %b want 0", uio_out[7]); end checks++;
    endtask

    task automatic test_oneshot();
        send(3'd3, 8'd0);
        send(3'd2, 8'h05);
        send(3'd1, 8'h02);
        send(3'd6, 8'h00);
        repeat (3) cyc();
        if (uo_out !== 8'h05 || uio_out !== 8'h30) begin errors++; $display("FAIL shot_reach: got %h status %h want 05 status 30", uo_out, uio_out); end checks++;
        cyc();
        if (uo_out !== 8'h05 || uio_out !== 8'h60) begin errors++; $display("FAIL shot_done: got %h status %h want 05 status 60", uo_out, uio_out); end checks++;
        send(3'd2, 8'h05);
        if (uio_out[6] !== 1'b0) begin errors++; $display("FAIL done_cleared: got %b want 0", uio_out[6]); end checks++;
        send(3'd1, 8'h05);
        send(3'd6, 8'h00);
        if (uo_out !== 8'h05 || uio_out !== 8'h30) begin errors++; $display("FAIL shot_equal_start: got %h status %h want 05 status 30", uo_out, uio_out); end checks++;
        cyc();
        if (uo_out !== 8'h05 || uio_out !== 8'h60) begin errors++; $display("FAIL shot_equal_done: got %h status %h want 05 status 60", uo_out, uio_out); end checks++;
    endtask

    task automatic test_strobe_hold();
        logic [7:0] e;
        send(3'd3, 8'd0);
        send(3'd1, 8'h00);
        uio_in[3] = 1'b0;
        cyc();
        uio_in = {4'b0000, 1'b1, 3'd4};
        repeat (10) cyc();
        uio_in[3] = 1'b0;
        e = 8'(10 - 1 - SS);
        if (uo_out !== e) begin errors++; $display("FAIL strobe_hold: got %h want %h", uo_out, e); end checks++;
        send(3'd1, 8'hAA);
        if (uo_out !== 8'hAA || uio_out[4] !== 1'b1) begin errors++; $display("FAIL cmd_beats_tick: got %h busy %b want aa busy 1", uo_out, uio_out[4]); end checks++;
        cyc();
        if (uo_out !== 8'hAB) begin errors++; $display("FAIL after_load_tick: got %h want ab", uo_out); end checks++;
        send(3'd7, 8'h00);
    endtask

    task automatic test_reset_mid_run();
        send(3'd3, 8'd1);
        send(3'd2, 8'h80);
        send(3'd1, 8'h00);
        send(3'd6, 8'h00);
        repeat (6) cyc();
        if (uio_out[4] !== 1'b1) begin errors++; $display("FAIL shot_running: got %b want 1", uio_out[4]); end checks++;
        rst_n = 1'b0;
        cyc();
        if ({uo_out, uio_out, uio_oe} !== 24'h0000F0) begin errors++; $display("FAIL mid_reset: got %h want 0000f0", {uo_out, uio_out, uio_oe}); end checks++;
        ui_in  = 8'h33;
        uio_in = {4'b0000, 1'b1, 3'd1};
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (SS + 1) cyc();
        if (uo_out !== 8'h33) begin errors++; $display("FAIL held_strobe_release: got %h want 33", uo_out); end checks++;
        uio_in[3] = 1'b0;
        send(3'd1, 8'hFF);
        if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL cmp_reset_value: match %b want 1", uio_out[5]); end checks++;
        send(3'd4, 8'h00);
        cyc();
        if (uo_out !== 8'h00 || uio_out[7] !== 1'b1) begin errors++; $display("FAIL presc_reset_value: got %h wrap %b want 00 wrap 1", uo_out, uio_out[7]); end checks++;
        send(3'd7, 8'h00);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [7:0]  arg;
        logic [3:0]  hi;
        logic [23:0] exp;
        int          gap;
        for (int n = 0; n < 250; n++) begin
            op  = 3'($urandom_range(1, 7));
            arg = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            if (op == 3'd3) arg = 8'($urandom_range(0, 3));
            hi  = 4'($urandom);
            gap = $urandom_range(0, 8);
            uio_in[3] = 1'b0;
            for (int c = 0; c < SS + 2 + gap; c++) begin
                if (c == 1) begin
                    ui_in  = arg;
                    uio_in = {hi, 1'b1, op};
                end
                if (c == SS + 2) uio_in[3] = 1'b0;
                cyc();
                exp = {m_count, exp_uio(), 8'hF0};
                if ({uo_out, uio_out, uio_oe} !== exp) begin
                    errors++;
                    $display("FAIL random_%0d_%0d: got %h want %h", n, c, {uo_out, uio_out, uio_oe}, exp);
                end
                checks++;
            end
        end
        uio_in[3] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_prescale();
        test_wrap();
        test_oneshot();
        test_strobe_hold();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter CMP_RESET, default 8'hFF: reset value of the compare register.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on the command strobe (legal values 2..3).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ena  input  1  power-good; ignored.
REQ-006 ui_in  input  8  command operand (load / compare / prescale value); must be held stable while the strobe is high.
REQ-007 uio_in  input  8  [2:0] opcode, [3] cmd strobe (asynchronous pin), [7:4] unused.
REQ-008 uo_out  output  8  current count value.
REQ-009 uio_out  output  8  [3:0]=0, [4] busy, [5] match, [6] done, [7] wrap.
REQ-010 uio_oe  output  8  constant 8'hF0.

Function
REQ-011 Strobe SHALL pass through SYNC_STAGES flops plus one edge-detect flop; one rising edge = exactly one command pulse.
- Command effect becomes visible SYNC_STAGES+1 edges after the first edge at which the strobe is sampled high.
REQ-012 Opcode and operand SHALL be sampled in the pulse cycle.
REQ-013 Opcodes:
- 000 NOP
- 001 LOAD: count<=operand, wrap<=0
- 010 SET_CMP: cmp<=operand
- 011 SET_PRESC: presc<=operand
- 100 RUN_UP
- 101 RUN_DOWN
- 110 ONESHOT
- 111 STOP
REQ-014 FSM states IDLE, UP, DOWN, SHOT:
- RUN_UP -> UP, RUN_DOWN -> DOWN, ONESHOT -> SHOT, from any state.
- STOP -> IDLE from any state; STOP in IDLE has no effect.
- SHOT -> IDLE on completion.
REQ-015 Prescaler pcnt SHALL:
- be held at 0 in IDLE
- be cleared by every non-NOP command pulse
- otherwise generate tick when pcnt==presc (then pcnt<=0), else pcnt<=pcnt+1
- presc=0 gives a tick every cycle.
REQ-016 On tick:
- UP: count<=count+1
- DOWN: count<=count-1
- arithmetic modulo 256.
REQ-017 UP 8'hFF->8'h00 and DOWN 8'h00->8'hFF SHALL set sticky wrap; wrap is cleared only by LOAD or reset.
REQ-018 On tick in SHOT:
- if count==cmp: go to IDLE, done<=1, count unchanged
- else count<=count+1 (wrap rules apply)
- count==cmp at entry completes on the first tick with no increment.
REQ-019 done SHALL be sticky, cleared by any non-NOP command pulse.
REQ-020 busy SHALL be (state!=IDLE); match SHALL be combinational (count==cmp).
REQ-021 Command pulse and tick in the same cycle: command wins, tick discarded.
REQ-022 LOAD/SET_CMP/SET_PRESC while running SHALL leave the state unchanged.

Reset
REQ-023 While rst_n is sampled low:
- count=0, cmp=CMP_RESET, presc=0, pcnt=0
- state=IDLE, done=0, wrap=0
- all synchronizer/edge flops=0
REQ-024 Reset mid-run SHALL abort immediately; a strobe held high across reset release SHALL produce one pulse after release.

Structure
REQ-025 Package counter_seq_pkg SHALL hold opcode constants, the state enum and status-bit indices.
REQ-026 Sub-module cmd_sync SHALL implement the strobe synchronizer and rising-edge pulse.

Verification
REQ-027 LOAD 8'h10, RUN_UP, presc=0, 5 cycles: count 8'h15, busy=1; STOP -> count held, busy=0.
REQ-028 SET_PRESC 3, LOAD 0, RUN_UP: increments every 4th edge; first increment 4 edges after the action edge.
REQ-029 LOAD 8'hFE, RUN_UP: 8'hFF then 8'h00 with wrap=1; LOAD 0 clears wrap. Same check for DOWN from 8'h01 to 8'hFF.
REQ-030 SET_CMP 8'h05, LOAD 8'h02, ONESHOT: stops at 8'h05, done=1, match=1, busy=0. Then SET_CMP 8'h05, LOAD 8'h05, ONESHOT: done after one tick, count stays 8'h05.
REQ-031 Strobe held high 10 cycles with RUN_UP: exactly one command pulse. Pulse coincident with tick (LOAD 8'hAA): count=8'hAA, no increment.
REQ-032 rst_n low mid-ONESHOT: all outputs return to reset values on the next edge; cmp reads as CMP_RESET.
